// File: rtl/ternary_frame_fetcher_pkg.sv
// Shared PT-5 trit encoding, frame-fetch FSM states and the buffered pair layout.
// Combinational definitions only; no latency or flow control of its own.
package tfmbs_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  localparam logic [7:0] PT5_MAX   = 8'd242;
  localparam int         PT5_TRITS = 5;
  localparam int         TRIT_BITS = 2 * PT5_TRITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [TRIT_BITS-1:0] w;
    logic [TRIT_BITS-1:0] x;
    logic                 last;
  } pair_t;

endpackage

// File: rtl/ternary_frame_fetcher_if.sv
// Unpacked trit-pair stream with valid/ready handshake.
// Data must hold while valid is high and ready is low.
interface ternary_frame_fetcher_if;
  import tfmbs_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  logic [TRIT_BITS-1:0] out_w;
  logic [TRIT_BITS-1:0] out_x;
  logic                 out_last;

  modport master (output out_valid, output out_w, output out_x, output out_last, input out_ready);
  modport slave  (input out_valid, input out_w, input out_x, input out_last, output out_ready);

endinterface

// File: rtl/ternary_frame_fetcher_pt5_unpack.sv
// PT-5 byte to 5 trits (base-3 digits, LSD first); zero latency, no flow control.
// Bytes above 242 are not PT-5 codes: they yield all-zero trits and raise invalid.
module pt5_unpack
  import tfmbs_pkg::*;
(
  input  logic [7:0]           byte_in,
  output logic [TRIT_BITS-1:0] trits,
  output logic                 invalid
);

  logic [7:0] rem;
  logic [7:0] digit;

  always_comb begin
    trits   = '0;
    rem     = byte_in;
    digit   = '0;
    invalid = (byte_in > PT5_MAX);
    for (int i = 0; i < PT5_TRITS; i++) begin
      digit = rem % 8'd3;
      case (digit)
        8'd1:    trits[2*i +: 2] = TRIT_POS;
        8'd2:    trits[2*i +: 2] = TRIT_NEG;
        default: trits[2*i +: 2] = TRIT_ZERO;
      endcase
      rem = rem / 8'd3;
    end
    if (invalid) trits = '0;
  end

endmodule

// File: rtl/ternary_frame_fetcher.sv
// Fetches len byte pairs from two SRAM banks, unpacks to trits; start to first out_valid is 3 cycles.
// Credit of 2 (in-flight reads + buffered pairs) stops reads under backpressure without losing data.
module ternary_frame_fetcher
  import tfmbs_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_a,
  input  logic [ADDR_WIDTH-1:0]   base_b,
  input  logic [ADDR_WIDTH:0]     len,
  output logic [ADDR_WIDTH-1:0]   addr_a,
  output logic [ADDR_WIDTH-1:0]   addr_b,
  output logic                    we_a,
  output logic                    we_b,
  input  logic [DATA_WIDTH-1:0]   dout_a,
  input  logic [DATA_WIDTH-1:0]   dout_b,
  ternary_frame_fetcher_if.master stream,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  state_t               state;
  logic [ADDR_WIDTH:0]  len_q;
  logic [ADDR_WIDTH:0]  cnt;
  logic                 rd_vld;
  logic                 rd_last;
  pair_t                fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           fifo_cnt;
  logic [TRIT_BITS-1:0] trits_a;
  logic [TRIT_BITS-1:0] trits_b;
  logic                 bad_a;
  logic                 bad_b;
  logic                 pop;
  logic                 issue;
  logic                 last_issue;
  pair_t                head;

  pt5_unpack u_unpack_a (.byte_in(dout_a), .trits(trits_a), .invalid(bad_a));
  pt5_unpack u_unpack_b (.byte_in(dout_b), .trits(trits_b), .invalid(bad_b));

  assign we_a = 1'b0;
  assign we_b = 1'b0;

  assign head             = fifo_mem[rd_ptr];
  assign stream.out_valid = (fifo_cnt != 2'd0);
  assign stream.out_w     = head.w;
  assign stream.out_x     = head.x;
  assign stream.out_last  = head.last;

  assign pop        = stream.out_valid && stream.out_ready;
  // Counting this cycle's pop as returned credit keeps a one-pair-per-cycle stream.
  assign issue      = (state == S_RUN) &&
                      ((3'(rd_vld) + 3'(fifo_cnt) - 3'(pop)) < 3'd2);
  assign last_issue = (cnt == len_q - (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_q       <= '0;
      cnt         <= '0;
      addr_a      <= '0;
      addr_b      <= '0;
      rd_vld      <= 1'b0;
      rd_last     <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rd_vld  <= issue;
      rd_last <= issue && last_issue;
      done    <= 1'b0;

      if (issue) begin
        addr_a <= addr_a + ADDR_WIDTH'(1);
        addr_b <= addr_b + ADDR_WIDTH'(1);
        cnt    <= cnt + (ADDR_WIDTH+1)'(1);
      end

      // SRAM data returns one cycle after issue and is decoded on the way in.
      if (rd_vld) begin
        fifo_mem[wr_ptr] <= '{w: trits_a, x: trits_b, last: rd_last};
        wr_ptr           <= ~wr_ptr;
        if (bad_a || bad_b) err <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(rd_vld) - 2'(pop);

      case (state)
        S_IDLE: begin
          if (start) begin
            addr_a <= base_a;
            addr_b <= base_b;
            len_q  <= len;
            cnt    <= '0;
            err    <= 1'b0;
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue && last_issue) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && head.last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_frame_fetcher.sv
// Randomized frames against a queue-based PT-5 reference; covers decode, errors, stalls, wrap, zero length, reset abort.
module tb_ternary_frame_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] base_a, base_b;
  logic [12:0] len;
  logic [11:0] addr_a, addr_b;
  logic        we_a, we_b;
  logic [7:0]  dout_a, dout_b;
  logic        busy, done, err;

  logic [7:0]  mem_a [4096];
  logic [7:0]  mem_b [4096];

  int n_checks = 0;
  int n_errors = 0;

  ternary_frame_fetcher_if sif ();

  ternary_frame_fetcher #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_a(base_a), .base_b(base_b), .len(len),
    .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b),
    .dout_a(dout_a), .dout_b(dout_b),
    .stream(sif),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // SRAM banks with one-cycle read latency
  always @(posedge clk) begin
    dout_a <= mem_a[addr_a];
    dout_b <= mem_b[addr_b];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ref_decode(input int v);
    logic [9:0] r;
    int p, d;
    r = '0;
    p = 1;
    if (v > 242) return r;
    for (int i = 0; i < 5; i++) begin
      d = (v / p) % 3;
      r[2*i +: 2] = (d == 1) ? 2'b01 : (d == 2) ? 2'b10 : 2'b00;
      p = p * 3;
    end
    return r;
  endfunction

  // mode 0: ready high, 1: ready 1-0-0-1 pattern, 2: random ready and stray start pulses
  task automatic run_frame(input logic [11:0] ba, input logic [11:0] bb, input int ln,
                           input int mode, input int abort_pair);
    logic [9:0] ew[$];
    logic [9:0] ex[$];
    logic       el[$];
    logic       exp_err, stalled, pl;
    logic [9:0] pw, px;
    logic [11:0] ia, ib;
    int c, acc, first_vld, done_cnt, done_cycle, last_hs, max_lead, lead;

    exp_err = 1'b0;
    for (int i = 0; i < ln; i++) begin
      ia = ba + 12'(i);
      ib = bb + 12'(i);
      ew.push_back(ref_decode(int'(mem_a[ia])));
      ex.push_back(ref_decode(int'(mem_b[ib])));
      el.push_back(i == ln - 1);
      if (mem_a[ia] > 8'd242 || mem_b[ib] > 8'd242) exp_err = 1'b1;
    end

    acc = 0; first_vld = -1; done_cnt = 0; done_cycle = -1; last_hs = -1;
    max_lead = 0; stalled = 1'b0; pw = '0; px = '0; pl = 1'b0;

    @(negedge clk);
    base_a = ba; base_b = bb; len = 13'(ln); start = 1'b1;
    c = 0;
    while (c < 300 && done_cnt == 0) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (mode == 2 && (c == 2 || c == 3)) begin
        start  = 1'($urandom_range(0, 1));
        base_a = 12'($urandom);
        len    = 13'($urandom_range(0, 9));
      end
      case (mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: sif.out_ready = 1'($urandom_range(0, 1));
      endcase

      if (c == 1) begin
        check_eq("addr_a_first", addr_a, ba);
        check_eq("addr_b_first", addr_b, bb);
        check_eq("busy_after_start", busy, (ln != 0));
        check_eq("err_cleared", err, 1'b0);
      end

      if (abort_pair >= 0 && acc == abort_pair) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", sif.out_valid, 1'b0);
        check_eq("abort_outs", {sif.out_w, sif.out_x, sif.out_last}, '0);
        check_eq("abort_ctrl", {busy, done, err}, 3'b000);
        check_eq("abort_addr", {addr_a, addr_b}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_no_done", done, 1'b0);
        return;
      end

      if (done) begin
        done_cnt++;
        done_cycle = c;
        check_eq("busy_low_in_done", busy, 1'b0);
      end
      if (sif.out_valid && first_vld < 0) first_vld = c;

      lead = int'(addr_a - ba) - acc;
      if (lead > max_lead) max_lead = lead;

      if (stalled) begin
        check_eq("stall_valid", sif.out_valid, 1'b1);
        check_eq("stall_data", {sif.out_w, sif.out_x, sif.out_last}, {pw, px, pl});
      end

      if (sif.out_valid && sif.out_ready) begin
        if (acc < ln) begin
          check_eq("pair_w", sif.out_w, ew[acc]);
          check_eq("pair_x", sif.out_x, ex[acc]);
          check_eq("pair_last", sif.out_last, el[acc]);
        end else begin
          check_eq("extra_pair", acc, ln - 1);
        end
        if (acc == ln - 1) last_hs = c;
        acc++;
        stalled = 1'b0;
      end else begin
        stalled = sif.out_valid;
        pw = sif.out_w; px = sif.out_x; pl = sif.out_last;
      end
    end

    check_eq("done_seen", done_cnt, 1);
    check_eq("pairs_accepted", acc, ln);
    check_eq("done_cycle", done_cycle, (ln == 0) ? 1 : last_hs + 1);
    check_eq("first_valid_cycle", first_vld, (ln == 0) ? -1 : 3);
    check_eq("addr_lead_le2", (max_lead <= 2), 1'b1);
    check_eq("err_flag", err, exp_err);
    @(negedge clk);
    @(negedge clk);
    check_eq("done_single_pulse", done, 1'b0);
    check_eq("err_hold", err, exp_err);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_a = '0; base_b = '0; len = '0;
    sif.out_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 8'($urandom_range(0, 242));
      mem_b[i] = 8'($urandom_range(0, 242));
    end
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", sif.out_valid, 1'b0);
    check_eq("rst_ctrl", {busy, done, err}, 3'b000);
    check_eq("rst_addr", {addr_a, addr_b}, '0);
    check_eq("rst_we", {we_a, we_b}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Decode corners on the weight bank
    mem_a[12'h100] = 8'd0;  mem_a[12'h101] = 8'd1;
    mem_a[12'h102] = 8'd121; mem_a[12'h103] = 8'd242;
    run_frame(12'h100, 12'h200, 4, 0, -1);

    // Invalid input-bank byte; err must clear on the next start
    mem_b[12'h302] = 8'hF3;
    run_frame(12'h400, 12'h300, 5, 0, -1);

    run_frame(12'h500, 12'h600, 8, 1, -1);

    // Wrap past the top of both banks
    mem_a[12'hFFE] = 8'd5; mem_a[12'hFFF] = 8'd77;
    mem_a[12'h000] = 8'd200; mem_a[12'h001] = 8'd13;
    run_frame(12'hFFE, 12'hFFD, 4, 0, -1);

    run_frame(12'h010, 12'h020, 0, 0, -1);

    run_frame(12'h700, 12'h800, 8, 0, 2);
    run_frame(12'h700, 12'h800, 8, 1, -1);

    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) mem_b[$urandom_range(0, 4095)] = 8'($urandom_range(243, 255));
      run_frame(12'($urandom), 12'($urandom), $urandom_range(1, 20), 2, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
